// File: rtl/mem_arb_2to1.sv
// Two-requester arbiter (instruction fetch, load/store) for the single-port simulation RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is LSU priority with IF starvation override.
module mem_arb_2to1 #(
  parameter logic [63:0] RAM_BASE   = 64'h0000_0000_8000_0000,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [63:0] lsu_req_wdata,
  input  logic [63:0] lsu_req_wmask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_resp_rdata,
  output logic        lsu_resp_err,
  output logic        mem_en,
  output logic [63:0] mem_idx,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  input  logic [63:0] mem_rdata
);

  logic        if_oor;
  logic        lsu_oor;
  logic [63:0] if_off;
  logic [63:0] lsu_off;
  logic        lsu_win;
  logic        if_gnt;
  logic        lsu_gnt;

  logic        if_resp_valid_reg;
  logic [31:0] if_resp_data_reg;
  logic        if_resp_err_reg;
  logic        lsu_resp_valid_reg;
  logic [63:0] lsu_resp_rdata_reg;
  logic        lsu_resp_err_reg;

  assign if_oor  = if_req_addr < RAM_BASE;
  assign lsu_oor = lsu_req_addr < RAM_BASE;
  assign if_off  = if_req_addr - RAM_BASE;
  assign lsu_off = lsu_req_addr - RAM_BASE;

`ifdef MEM_ARB_RR_EN
  typedef enum logic {GRANT_IF = 1'b0, GRANT_LSU = 1'b1} grant_t;
  grant_t last_grant_reg;

  // On contention the side that did not win last time goes first.
  assign lsu_win = lsu_req_valid && (!if_req_valid || (last_grant_reg == GRANT_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= GRANT_IF;
    end else if (if_gnt) begin
      last_grant_reg <= GRANT_IF;
    end else if (lsu_gnt) begin
      last_grant_reg <= GRANT_LSU;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;

  assign lsu_win = lsu_req_valid && !(if_req_valid && (starve_cnt_reg == STARVE_LIM));

  // Counts consecutive cycles in which a waiting fetch lost to the LSU.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (if_req_valid && lsu_gnt) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_LIM) ? STARVE_LIM : starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`endif

  // Both grants are held low while reset is asserted so no RAM access leaks through.
  assign lsu_gnt = rst_n && lsu_win;
  assign if_gnt  = rst_n && if_req_valid && !lsu_win;

  assign if_req_ready  = if_gnt;
  assign lsu_req_ready = lsu_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 1'b0;
    mem_idx   = 64'd0;
    mem_wdata = 64'd0;
    mem_wmask = 64'd0;
    if (lsu_gnt) begin
      mem_en    = !lsu_oor;
      mem_wen   = lsu_req_wen && !lsu_oor;
      mem_idx   = lsu_off >> 3;
      mem_wdata = lsu_req_wdata;
      mem_wmask = lsu_req_wmask;
    end else if (if_gnt) begin
      mem_en  = !if_oor;
      mem_idx = if_off >> 3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_resp_valid_reg  <= 1'b0;
      if_resp_data_reg   <= 32'd0;
      if_resp_err_reg    <= 1'b0;
      lsu_resp_valid_reg <= 1'b0;
      lsu_resp_rdata_reg <= 64'd0;
      lsu_resp_err_reg   <= 1'b0;
    end else begin
      if_resp_valid_reg  <= if_gnt;
      lsu_resp_valid_reg <= lsu_gnt;
      if (if_gnt) begin
        if_resp_err_reg  <= if_oor;
        if_resp_data_reg <= if_oor ? 32'd0 :
                            (if_req_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]);
      end
      if (lsu_gnt) begin
        lsu_resp_err_reg   <= lsu_oor;
        lsu_resp_rdata_reg <= (lsu_oor || lsu_req_wen) ? 64'd0 : mem_rdata;
      end
    end
  end

  assign if_resp_valid  = if_resp_valid_reg;
  assign if_resp_data   = if_resp_data_reg;
  assign if_resp_err    = if_resp_err_reg;
  assign lsu_resp_valid = lsu_resp_valid_reg;
  assign lsu_resp_rdata = lsu_resp_rdata_reg;
  assign lsu_resp_err   = lsu_resp_err_reg;

endmodule
